digdug_hvgen: RTL and testbench



---
 rtl/digdug_video_pkg.sv | 29 ++
 rtl/digdug_irqlatch.sv | 24 ++
 rtl/digdug_hvgen.sv | 139 +++++++++++++
 tb/tb_digdug_hvgen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/digdug_video_pkg.sv
// DigDug video timing constants and shared decode helper.
// Used by the raster generator and downstream video blocks.
package digdug_video_pkg;

  localparam int POS_W = 9;

  localparam int HTOTAL_D   = 384;
  localparam int HACTIVE_D  = 288;
  localparam int HS_START_D = 304;
  localparam int HS_WIDTH_D = 32;
  localparam int VTOTAL_D   = 264;
  localparam int VACTIVE_D  = 224;
  localparam int VS_START_D = 240;
  localparam int VS_WIDTH_D = 4;

  // Signed window test so an offset start may fall below zero.
  function automatic logic in_win(
    input logic        [POS_W-1:0] pos,
    input logic signed [10:0]      lo,
    input logic        [POS_W-1:0] w
  );
    logic signed [10:0] p;
    logic signed [10:0] hi;
    p  = $signed({2'b00, pos});
    hi = lo + $signed({2'b00, w});
    return (p >= lo) && (p < hi);
  endfunction

endpackage

// File: rtl/digdug_irqlatch.sv
// Interrupt request latch: enable clears, set beats acknowledge.
// Shared by the VBLANK, sound and sub-CPU interrupt sources.
module digdug_irqlatch (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  input  logic en,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (!en) begin
      q <= 1'b0;
    end else if (req) begin
      q <= 1'b1;
    end else if (ack) begin
      q <= 1'b0;
    end
  end

endmodule

// File: rtl/digdug_hvgen.sv
// DigDug raster timing: pixel enable, position, blank, sync, frame, VBIRQ.
// DIGDUG_HVPOS_ADJ_EN adds frame-latched HOFS/VOFS sync centering inputs.
module digdug_hvgen
  import digdug_video_pkg::*;
#(
  parameter int HTOTAL   = HTOTAL_D,
  parameter int HACTIVE  = HACTIVE_D,
  parameter int HS_START = HS_START_D,
  parameter int HS_WIDTH = HS_WIDTH_D,
  parameter int VTOTAL   = VTOTAL_D,
  parameter int VACTIVE  = VACTIVE_D,
  parameter int VS_START = VS_START_D,
  parameter int VS_WIDTH = VS_WIDTH_D
) (
  input  logic             CLK48M,
  input  logic             RESET,
  output logic             PCE,
  output logic [POS_W-1:0] POSH,
  output logic [POS_W-1:0] POSV,
  output logic             HBLK,
  output logic             VBLK,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic [7:0]       FRAME,
`ifdef DIGDUG_HVPOS_ADJ_EN
  input  logic signed [3:0] HOFS,
  input  logic signed [2:0] VOFS,
`endif
  input  logic             IRQ_EN,
  input  logic             IRQ_ACK,
  output logic             VBIRQ
);

  if (HS_START + HS_WIDTH > HTOTAL) begin : g_bad_hs
    $error("HSYNC window exceeds HTOTAL");
  end
  if (VS_START + VS_WIDTH > VTOTAL) begin : g_bad_vs
    $error("VSYNC window exceeds VTOTAL");
  end
  if (HTOTAL > 512 || VTOTAL > 512) begin : g_bad_tot
    $error("HTOTAL/VTOTAL exceed 9-bit position");
  end

  localparam logic [POS_W-1:0] H_LAST  = POS_W'(HTOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST  = POS_W'(VTOTAL - 1);
  localparam logic [POS_W-1:0] VA_LAST = POS_W'(VACTIVE - 1);
  localparam logic [POS_W-1:0] H_ACT   = POS_W'(HACTIVE);
  localparam logic [POS_W-1:0] V_ACT   = POS_W'(VACTIVE);
  localparam logic [POS_W-1:0] HS_W    = POS_W'(HS_WIDTH);
  localparam logic [POS_W-1:0] VS_W    = POS_W'(VS_WIDTH);
  localparam logic signed [10:0] HS_LO = 11'(HS_START);
  localparam logic signed [10:0] VS_LO = 11'(VS_START);

  logic [2:0]       phase;
  logic [POS_W-1:0] nxt_h;
  logic [POS_W-1:0] nxt_v;
  logic             h_end;
  logic             v_last;
  logic             f_wrap;
  logic             irq_req;
  logic signed [10:0] hs_lo;
  logic signed [10:0] vs_lo;

  assign h_end   = PCE && (POSH == H_LAST);
  assign v_last  = (POSV == V_LAST);
  assign f_wrap  = h_end && v_last;
  assign irq_req = h_end && (POSV == VA_LAST);

  always_comb begin
    nxt_h = POSH;
    nxt_v = POSV;
    if (PCE) begin
      nxt_h = h_end ? '0 : POSH + 1'b1;
      if (h_end) begin
        nxt_v = v_last ? '0 : POSV + 1'b1;
      end
    end
  end

`ifdef DIGDUG_HVPOS_ADJ_EN
  logic signed [3:0] hofs_q;
  logic signed [3:0] hofs_n;
  logic signed [2:0] vofs_q;
  logic signed [2:0] vofs_n;

  // New offsets take effect on the first position of the new frame.
  assign hofs_n = f_wrap ? HOFS : hofs_q;
  assign vofs_n = f_wrap ? VOFS : vofs_q;
  assign hs_lo  = HS_LO + {{7{hofs_n[3]}}, hofs_n};
  assign vs_lo  = VS_LO + {{8{vofs_n[2]}}, vofs_n};

  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      hofs_q <= '0;
      vofs_q <= '0;
    end else begin
      hofs_q <= hofs_n;
      vofs_q <= vofs_n;
    end
  end
`else
  assign hs_lo = HS_LO;
  assign vs_lo = VS_LO;
`endif

  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      phase <= '0;
      PCE   <= 1'b0;
      POSH  <= '0;
      POSV  <= '0;
      HBLK  <= 1'b0;
      VBLK  <= 1'b0;
      HSYNC <= 1'b0;
      VSYNC <= 1'b0;
      FRAME <= '0;
    end else begin
      phase <= phase + 3'd1;
      PCE   <= (phase == 3'd6);
      POSH  <= nxt_h;
      POSV  <= nxt_v;
      HBLK  <= (nxt_h >= H_ACT);
      VBLK  <= (nxt_v >= V_ACT);
      HSYNC <= in_win(nxt_h, hs_lo, HS_W);
      VSYNC <= in_win(nxt_v, vs_lo, VS_W);
      FRAME <= FRAME + {7'd0, f_wrap};
    end
  end

  digdug_irqlatch u_vbirq (
    .clk (CLK48M),
    .rst (RESET),
    .req (irq_req),
    .ack (IRQ_ACK),
    .en  (IRQ_EN),
    .q   (VBIRQ)
  );

endmodule

// File: tb/tb_digdug_hvgen.sv
// Randomized check of digdug_hvgen against a cycle-count raster model.
// Uses a shrunk raster so several whole frames fit in a short run.
module tb_digdug_hvgen;

  localparam int HT  = 24;
  localparam int HA  = 18;
  localparam int HSS = 19;
  localparam int HSW = 2;
  localparam int VT  = 12;
  localparam int VA  = 9;
  localparam int VSS = 10;
  localparam int VSW = 2;
  localparam int F   = 8 * HT * VT;
  localparam int NCYC = 24000;

  logic       clk = 1'b0;
  logic       RESET;
  logic       PCE;
  logic [8:0] POSH;
  logic [8:0] POSV;
  logic       HBLK;
  logic       VBLK;
  logic       HSYNC;
  logic       VSYNC;
  logic [7:0] FRAME;
  logic       IRQ_EN;
  logic       IRQ_ACK;
  logic       VBIRQ;
`ifdef DIGDUG_HVPOS_ADJ_EN
  logic signed [3:0] HOFS;
  logic signed [2:0] VOFS;
`endif

  always #5 clk = ~clk;

  digdug_hvgen #(
    .HTOTAL(HT), .HACTIVE(HA), .HS_START(HSS), .HS_WIDTH(HSW),
    .VTOTAL(VT), .VACTIVE(VA), .VS_START(VSS), .VS_WIDTH(VSW)
  ) dut (
    .CLK48M  (clk),
    .RESET   (RESET),
    .PCE     (PCE),
    .POSH    (POSH),
    .POSV    (POSV),
    .HBLK    (HBLK),
    .VBLK    (VBLK),
    .HSYNC   (HSYNC),
    .VSYNC   (VSYNC),
    .FRAME   (FRAME),
`ifdef DIGDUG_HVPOS_ADJ_EN
    .HOFS    (HOFS),
    .VOFS    (VOFS),
`endif
    .IRQ_EN  (IRQ_EN),
    .IRQ_ACK (IRQ_ACK),
    .VBIRQ   (VBIRQ)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_h(input int cc);
    return (cc / 8) % HT;
  endfunction
  function automatic int m_v(input int cc);
    return ((cc / 8) / HT) % VT;
  endfunction
  function automatic int m_f(input int cc);
    return (((cc / 8) / HT) / VT) % 256;
  endfunction
  function automatic bit m_pce(input int cc);
    return (cc % 8) == 7;
  endfunction

  int c;
  bit m_irq;
  int m_ho;
  int m_vo;
  bit did_rst;
  bit prev_hs;
  bit have_rise;
  int rise_k;
  int prev_frame;
  bit have_frame;
  int frame_k;

  initial begin
    int h, v, r;
    bit set_c, wrap_c;
    RESET = 1'b1;
    IRQ_EN = 1'b1;
    IRQ_ACK = 1'b0;
`ifdef DIGDUG_HVPOS_ADJ_EN
    HOFS = '0;
    VOFS = '0;
`endif
    repeat (2) @(posedge clk);
    c = 0; m_irq = 0; m_ho = 0; m_vo = 0;
    did_rst = 0; prev_hs = 0; have_rise = 0;
    prev_frame = 0; have_frame = 0;
    rise_k = 0; frame_k = 0;

    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      h = m_h(c);
      v = m_v(c);
      chk("pce",   PCE,   m_pce(c));
      chk("posh",  POSH,  h);
      chk("posv",  POSV,  v);
      chk("frame", FRAME, m_f(c));
      chk("hblk",  HBLK,  h >= HA);
      chk("vblk",  VBLK,  v >= VA);
      chk("hsync", HSYNC, (h >= HSS + m_ho) && (h < HSS + m_ho + HSW));
      chk("vsync", VSYNC, (v >= VSS + m_vo) && (v < VSS + m_vo + VSW));
      chk("vbirq", VBIRQ, m_irq);

      if (HSYNC && !prev_hs) begin
        rise_k = k;
        have_rise = 1;
      end
      if (!HSYNC && prev_hs && have_rise)
        chk("hs_width", k - rise_k, 8 * HSW);
      prev_hs = HSYNC;
      if (int'(FRAME) != prev_frame) begin
        if (have_frame) chk("period", k - frame_k, F);
        have_frame = 1;
        frame_k = k;
      end
      prev_frame = int'(FRAME);

      set_c  = m_pce(c) && h == HT - 1 && v == VA - 1;
      wrap_c = m_pce(c) && h == HT - 1 && v == VT - 1;

      RESET = 1'b0;
      if (!did_rst && k > 6 * F && m_pce(c) && h == 15 && v == 5) begin
        RESET = 1'b1;
        did_rst = 1;
      end
      IRQ_EN = !(k >= 4 * F && k < 5 * F + 200);
      IRQ_ACK = ($urandom_range(0, 399) == 0);
      if (k >= 2 * F && k < 3 * F && set_c) IRQ_ACK = 1'b1;
      if (m_irq && v == VA && h == 2 && (c % 8) == 0) IRQ_ACK = 1'b1;
`ifdef DIGDUG_HVPOS_ADJ_EN
      if (k % 777 == 300) begin
        r = int'($urandom_range(0, 11)) - 8;
        HOFS = 4'(r);
        r = int'($urandom_range(0, 5)) - 4;
        VOFS = 3'(r);
      end
`endif

      @(posedge clk);
      if (RESET) begin
        c = 0; m_irq = 0; m_ho = 0; m_vo = 0;
        prev_hs = 0; have_rise = 0;
        prev_frame = 0; have_frame = 0;
      end else begin
        if (!IRQ_EN) m_irq = 0;
        else if (set_c) m_irq = 1;
        else if (IRQ_ACK) m_irq = 0;
`ifdef DIGDUG_HVPOS_ADJ_EN
        if (wrap_c) begin
          m_ho = int'(HOFS);
          m_vo = int'(VOFS);
        end
`else
        if (wrap_c) begin
          m_ho = 0;
          m_vo = 0;
        end
`endif
        c++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
